// File: rtl/reg_dep_flush_ctrl.sv
// reg_dep_flush_ctrl
//   Recovery sequencer for the register-rename dependency table. When the RoB
//   flushes, it walks only the registers whose has_dep bit is set and issues
//   one clear per cycle to the register file. While the walk runs, it squashes
//   issue-time dependency writes so that no stale RoB tag survives the flush.
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset (wins over rdy)
//   rdy               global ready; low freezes state and pending
//   flush_req         RoB flush pulse
//   dep_mask          live has_dep vector from the register file
//   issue_rd_in       destination register of the issuing instruction
//   issue_rob_id_in   RoB tag of the issuing instruction
//   issue_rd_out      gated destination (0 while flushing/sweeping)
//   issue_rob_id_out  issue_rob_id_in passed through unchanged
//   issue_stall       high while not IDLE; Decoder must not issue
//   clr_valid         clear command valid
//   clr_idx           register to clear
//   flush_done        one-cycle pulse when the sweep completes
//
// state | meaning
// IDLE  | no recovery in progress, issue writes pass through
// SWEEP | clearing pending registers, lowest index first, one per rdy cycle
// DONE  | sweep finished, flush_done pulses on the next rdy cycle
module reg_dep_flush_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int REG_IDX_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush_req,
    input  logic [NUM_REGS-1:0]       dep_mask,
    input  logic [REG_IDX_WIDTH-1:0]  issue_rd_in,
    input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id_in,
    output logic [REG_IDX_WIDTH-1:0]  issue_rd_out,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id_out,
    output logic                      issue_stall,
    output logic                      clr_valid,
    output logic [REG_IDX_WIDTH-1:0]  clr_idx,
    output logic                      flush_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [NUM_REGS-1:0]      pending;

    logic [NUM_REGS-1:0]      flush_set;
    logic                     flush_set_nz;
    logic [REG_IDX_WIDTH-1:0] low_idx;
    logic [NUM_REGS-1:0]      pending_rest;
    logic [NUM_REGS-1:0]      sweep_next;

    // x0 is hard-wired and never carries a dependency, so it is never swept.
    assign flush_set    = {dep_mask[NUM_REGS-1:1], 1'b0};
    assign flush_set_nz = |flush_set;

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = REG_IDX_WIDTH'(i);
            end
        end
    end

    assign pending_rest = pending & ~(NUM_REGS'(1) << low_idx);
    // A flush during the sweep folds the new dependencies into what is left.
    assign sweep_next   = flush_req ? (pending_rest | flush_set) : pending_rest;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        pending <= flush_set;
                        state   <= flush_set_nz ? SWEEP : DONE;
                    end
                end
                SWEEP: begin
                    pending <= sweep_next;
                    if (!(|sweep_next)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A fresh flush with real work restarts the sweep and
                    // swallows this cycle's completion pulse.
                    if (flush_req && flush_set_nz) begin
                        pending <= flush_set;
                        state   <= SWEEP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

    assign issue_stall      = (state != IDLE);
    assign clr_valid        = rdy && (state == SWEEP);
    assign clr_idx          = low_idx;
    assign flush_done       = rdy && (state == DONE) && !(flush_req && flush_set_nz);
    assign issue_rd_out     = (flush_req || (state != IDLE)) ? '0 : issue_rd_in;
    assign issue_rob_id_out = issue_rob_id_in;

endmodule

// File: tb/tb_reg_dep_flush_ctrl.sv
// Bench for reg_dep_flush_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_dep_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush_req;
    logic [31:0] dep_mask;
    logic [4:0]  issue_rd_in;
    logic [3:0]  issue_rob_id_in;
    logic [4:0]  issue_rd_out;
    logic [3:0]  issue_rob_id_out;
    logic        issue_stall;
    logic        clr_valid;
    logic [4:0]  clr_idx;
    logic        flush_done;

    int checks   = 0;
    int failures = 0;

    reg_dep_flush_ctrl #(
        .NUM_REGS(32),
        .REG_IDX_WIDTH(5),
        .ROB_SIZE_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .flush_req(flush_req),
        .dep_mask(dep_mask),
        .issue_rd_in(issue_rd_in),
        .issue_rob_id_in(issue_rob_id_in),
        .issue_rd_out(issue_rd_out),
        .issue_rob_id_out(issue_rob_id_out),
        .issue_stall(issue_stall),
        .clr_valid(clr_valid),
        .clr_idx(clr_idx),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding registers as a sorted queue of indices,
    // plus a flag meaning "sweep finished, completion pulse owed".
    int mq[$];
    bit m_fin  = 1'b0;
    bit m_live = 1'b0;

    function automatic void merge(input logic [31:0] d);
        for (int i = 1; i < 32; i++) begin
            if (d[i]) begin
                bit found = 1'b0;
                foreach (mq[j]) if (mq[j] == i) found = 1'b1;
                if (!found) mq.push_back(i);
            end
        end
        mq.sort();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_fin  = 1'b0;
            m_live = 1'b1;
        end else if (m_live && rdy) begin
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                if (flush_req) merge(dep_mask);
                if (mq.size() == 0) m_fin = 1'b1;
            end else if (m_fin) begin
                m_fin = 1'b0;
                if (flush_req) merge(dep_mask);
            end else if (flush_req) begin
                merge(dep_mask);
                m_fin = (mq.size() == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            int  busy;
            int  has_new;
            busy    = (mq.size() > 0 || m_fin) ? 1 : 0;
            has_new = (|dep_mask[31:1]) ? 1 : 0;
            chk("m_stall", int'(issue_stall), busy);
            chk("m_clr_valid", int'(clr_valid), (rdy && mq.size() > 0) ? 1 : 0);
            if (rdy && mq.size() > 0) chk("m_clr_idx", int'(clr_idx), mq[0]);
            chk("m_flush_done", int'(flush_done),
                (rdy && m_fin && !(flush_req && has_new != 0)) ? 1 : 0);
            chk("m_rd_out", int'(issue_rd_out),
                (flush_req || busy != 0) ? 0 : int'(issue_rd_in));
            chk("m_rob_id", int'(issue_rob_id_out), int'(issue_rob_id_in));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        issue_rob_id_in = 4'($urandom_range(0, 15));
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int ids[3];
        rst = 1'b1; rdy = 1'b1; flush_req = 1'b1; dep_mask = 32'h0000_FFFF;
        issue_rd_in = 5'd7; issue_rob_id_in = 4'd0;

        // Reset with flush_req held high
        nxt();
        smp();
        chk("rst_stall", int'(issue_stall), 0);
        chk("rst_clr_valid", int'(clr_valid), 0);
        chk("rst_clr_idx", int'(clr_idx), 0);
        chk("rst_done", int'(flush_done), 0);
        chk("rst_rd_out", int'(issue_rd_out), 0);
        nxt();
        rst = 1'b0; flush_req = 1'b0; dep_mask = 32'h0;
        smp();
        chk("post_rst_rd", int'(issue_rd_out), 7);
        chk("post_rst_stall", int'(issue_stall), 0);

        // Basic sweep 1, 10, 15
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_8402; issue_rd_in = 5'd5;
        smp();
        chk("bs_c0_rd", int'(issue_rd_out), 0);
        chk("bs_c0_stall", int'(issue_stall), 0);
        ids = '{1, 10, 15};
        for (int c = 0; c < 3; c++) begin
            nxt();
            flush_req = 1'b0; dep_mask = 32'hFFFF_FFFF;
            smp();
            chk("bs_clr_valid", int'(clr_valid), 1);
            chk("bs_clr_idx", int'(clr_idx), ids[c]);
            chk("bs_stall", int'(issue_stall), 1);
            chk("bs_rd", int'(issue_rd_out), 0);
            chk("bs_done_early", int'(flush_done), 0);
        end
        nxt();
        smp();
        chk("bs_c4_done", int'(flush_done), 1);
        chk("bs_c4_clr_valid", int'(clr_valid), 0);
        chk("bs_c4_stall", int'(issue_stall), 1);
        chk("bs_c4_rd", int'(issue_rd_out), 0);
        nxt();
        smp();
        chk("bs_c5_stall", int'(issue_stall), 0);
        chk("bs_c5_done", int'(flush_done), 0);
        chk("bs_c5_rd", int'(issue_rd_out), 5);

        // Only x0 set: nothing to clear
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0001;
        nxt();
        flush_req = 1'b0;
        smp();
        chk("x0_clr_valid", int'(clr_valid), 0);
        chk("x0_done", int'(flush_done), 1);
        chk("x0_stall", int'(issue_stall), 1);
        nxt();
        smp();
        chk("x0_stall_after", int'(issue_stall), 0);

        // rdy low in DONE holds the completion pulse
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0;
        nxt();
        flush_req = 1'b0; rdy = 1'b0;
        smp();
        chk("dh_done_frozen", int'(flush_done), 0);
        chk("dh_stall", int'(issue_stall), 1);
        nxt();
        rdy = 1'b1;
        smp();
        chk("dh_done", int'(flush_done), 1);

        // rdy low in IDLE: a flush is ignored, but the issue write is squashed
        nxt();
        rdy = 1'b0; flush_req = 1'b1; dep_mask = 32'h0000_0002; issue_rd_in = 5'd9;
        smp();
        chk("ri_rd", int'(issue_rd_out), 0);
        nxt();
        rdy = 1'b1; flush_req = 1'b0;
        smp();
        chk("ri_stall", int'(issue_stall), 0);
        chk("ri_rd_pass", int'(issue_rd_out), 9);

        // rdy stall mid-sweep
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0030;
        nxt();
        flush_req = 1'b0;
        smp();
        chk("rs_clr4", int'(clr_idx), 4);
        chk("rs_clr4_valid", int'(clr_valid), 1);
        for (int c = 0; c < 3; c++) begin
            nxt();
            rdy = 1'b0;
            smp();
            chk("rs_frozen_valid", int'(clr_valid), 0);
            chk("rs_frozen_stall", int'(issue_stall), 1);
        end
        nxt();
        rdy = 1'b1;
        smp();
        chk("rs_clr5", int'(clr_idx), 5);
        chk("rs_clr5_valid", int'(clr_valid), 1);
        nxt();
        smp();
        chk("rs_done", int'(flush_done), 1);

        // Re-flush during SWEEP while the last pending clear is 9
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0208;
        nxt();
        flush_req = 1'b0;
        smp();
        chk("rf_clr3", int'(clr_idx), 3);
        nxt();
        flush_req = 1'b1; dep_mask = 32'h8000_0004;
        smp();
        chk("rf_clr9", int'(clr_idx), 9);
        ids = '{2, 31, 0};
        for (int c = 0; c < 2; c++) begin
            nxt();
            flush_req = 1'b0; dep_mask = 32'h0;
            smp();
            chk("rf_clr_valid", int'(clr_valid), 1);
            chk("rf_clr_idx", int'(clr_idx), ids[c]);
        end
        nxt();
        smp();
        chk("rf_done", int'(flush_done), 1);

        // Flush landing on the DONE cycle restarts the sweep
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0004;
        nxt();
        flush_req = 1'b0;
        smp();
        chk("fd_clr2", int'(clr_idx), 2);
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0040;
        smp();
        chk("fd_no_done", int'(flush_done), 0);
        nxt();
        flush_req = 1'b0;
        smp();
        chk("fd_clr6", int'(clr_idx), 6);
        chk("fd_clr6_valid", int'(clr_valid), 1);
        nxt();
        smp();
        chk("fd_done", int'(flush_done), 1);

        // Reset on the second clear cycle
        nxt();
        flush_req = 1'b1; dep_mask = 32'h0000_0F00;
        nxt();
        flush_req = 1'b0;
        smp();
        chk("mr_clr8", int'(clr_idx), 8);
        nxt();
        rst = 1'b1;
        smp();
        chk("mr_clr9", int'(clr_idx), 9);
        nxt();
        rst = 1'b0;
        smp();
        chk("mr_clr_valid", int'(clr_valid), 0);
        chk("mr_stall", int'(issue_stall), 0);
        for (int c = 0; c < 3; c++) begin
            nxt();
            smp();
            chk("mr_no_done", int'(flush_done), 0);
            chk("mr_no_clr", int'(clr_valid), 0);
        end

        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
